// File: rtl/mult_seq_16b.sv
// ============================================================================
// Module   : mult_seq_16b (with internal cla_16b adder)
// Brief    : 16x16 unsigned shift-add multiplier, one adder pass per cycle.
//            Optional early termination when MULT_EARLY_TERM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout,
  output logic        pout,
  output logic        gout
);
  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] c;
  logic [3:0]  grp_p;
  logic [3:0]  grp_g;
  logic [4:0]  grp_c;

  always_comb begin
    p = a ^ b;
    g = a & b;
    for (int k = 0; k < 4; k++) begin
      grp_p[k] = &p[4*k +: 4];
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
    // Second-level lookahead across the four nibble groups
    grp_c[0] = cin;
    grp_c[1] = grp_g[0] | (grp_p[0] & cin);
    grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
    grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
    grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);
    for (int k = 0; k < 4; k++) begin
      c[4*k] = grp_c[k];
      for (int j = 1; j < 4; j++) begin
        c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
      end
    end
    sum  = p ^ c;
    cout = grp_c[4];
    pout = &grp_p;
    gout = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
         | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);
  end
endmodule

module mult_seq_16b (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] m_q, m_d;
  logic [15:0] hi_q, hi_d;
  logic [15:0] lo_q, lo_d;
  logic [4:0]  cnt_q, cnt_d;

  logic [15:0] add_b;
  logic [15:0] add_sum;
  logic        add_cout;
  logic        adder_unused_p;
  logic        adder_unused_g;

  assign add_b = lo_q[0] ? m_q : 16'h0000;

  cla_16b u_cla (
    .a    (hi_q),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout),
    .pout (adder_unused_p),
    .gout (adder_unused_g)
  );

`ifdef MULT_EARLY_TERM_EN
  // Multiplier bits not yet consumed sit in lo_q[15-cnt:1]; once they are
  // all zero the remaining iterations would only shift, so do them at once.
  logic [14:0] rem_bits;
  logic [4:0]  rem_shift;
  logic [31:0] early_prod;

  always_comb begin
    rem_bits   = lo_q[15:1] & (15'h7FFF >> cnt_q);
    rem_shift  = 5'd15 - cnt_q;
    early_prod = {add_cout, add_sum, lo_q[15:1]} >> rem_shift;
  end
`endif

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d     = a;
          hi_d    = 16'h0000;
          lo_d    = b;
          cnt_d   = 5'd0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        hi_d  = {add_cout, add_sum[15:1]};
        lo_d  = {add_sum[0], lo_q[15:1]};
        cnt_d = cnt_q + 5'd1;
`ifdef MULT_EARLY_TERM_EN
        if (rem_bits == 15'h0000) begin
          hi_d    = early_prod[31:16];
          lo_d    = early_prod[15:0];
          state_d = ST_DONE;
        end
`else
        if (cnt_q == 5'd15) begin
          state_d = ST_DONE;
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      m_q     <= 16'h0000;
      hi_q    <= 16'h0000;
      lo_q    <= 16'h0000;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign product = {hi_q, lo_q};
endmodule

`default_nettype wire
